// File: rtl/ttl_uart_pkg.sv
// Shared types, state encodings and helpers for the half-duplex TTL UART.
package ttl_uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef logic [2:0] tx_state_e;
  localparam tx_state_e TX_IDLE  = 3'd0;
  localparam tx_state_e TX_START = 3'd1;
  localparam tx_state_e TX_DATA  = 3'd2;
  localparam tx_state_e TX_PAR   = 3'd3;
  localparam tx_state_e TX_STOP  = 3'd4;
  localparam tx_state_e TX_GUARD = 3'd5;

  typedef logic [2:0] rx_state_e;
  localparam rx_state_e RX_IDLE      = 3'd0;
  localparam rx_state_e RX_START_CHK = 3'd1;
  localparam rx_state_e RX_DATA      = 3'd2;
  localparam rx_state_e RX_PAR       = 3'd3;
  localparam rx_state_e RX_STOP      = 3'd4;
  localparam rx_state_e RX_PUSH      = 3'd5;

  localparam int unsigned MIN_BAUD_DIV = 4;

  // Callers zero-extend narrower data; the extra zeros do not change the XOR.
  function automatic logic parity_calc(input logic [8:0] data, input parity_e mode);
    return (^data) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/ttl_uart_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO is taken only with a same-cycle pop.
module ttl_uart_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ttl_uart_hd.sv
// Half-duplex single-wire UART: runtime divisor, configurable framing, RX FIFO with overrun.
module ttl_uart_hd
  import ttl_uart_pkg::*;
#(
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned PARITY        = 0,
  parameter int unsigned STOP_BITS     = 1,
  parameter int unsigned RX_FIFO_DEPTH = 16,
  parameter int unsigned DIV_W         = 16,
  parameter int unsigned GUARD_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 half_duplex_en,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_active,
  output logic [DATA_BITS-1:0] rx_data,
  output logic [1:0]           rx_err,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_overrun,
  input  logic                 clr_overrun,
  input  logic                 serial_i,
  output logic                 serial_o,
  output logic                 serial_oe
);
  localparam int unsigned BCW      = $clog2(DATA_BITS + 1);
  localparam parity_e     PAR_MODE = parity_e'(PARITY[1:0]);

  logic [DIV_W-1:0] div_eff;
  assign div_eff = (baud_div < DIV_W'(MIN_BAUD_DIV)) ? DIV_W'(MIN_BAUD_DIV) : baud_div;

  // ---------------- TX ----------------
  tx_state_e            tx_state;
  logic [DIV_W-1:0]     tx_div, tx_cnt;
  logic [BCW-1:0]       tx_bit;
  logic [DATA_BITS-1:0] tx_sh;
  logic                 tx_par, init_done, tx_tick;

  assign tx_tick   = (tx_cnt == tx_div - DIV_W'(1));
  assign tx_ready  = (tx_state == TX_IDLE) & half_duplex_en & init_done;
  assign tx_active = (tx_state != TX_IDLE);
  assign serial_oe = tx_active;

  always_comb begin
    serial_o = 1'b1;
    if (tx_state == TX_START)     serial_o = 1'b0;
    else if (tx_state == TX_DATA) serial_o = tx_sh[0];
    else if (tx_state == TX_PAR)  serial_o = tx_par;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state  <= TX_IDLE;
      tx_div    <= DIV_W'(MIN_BAUD_DIV);
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_sh     <= '0;
      tx_par    <= 1'b0;
      init_done <= 1'b0;
    end else begin
      init_done <= 1'b1;
      if (tx_state == TX_IDLE) begin
        if (tx_valid && tx_ready) begin
          tx_sh    <= tx_data;
          tx_par   <= parity_calc(9'(tx_data), PAR_MODE);
          tx_div   <= div_eff;
          tx_cnt   <= '0;
          tx_bit   <= '0;
          tx_state <= TX_START;
        end
      end else if (!tx_tick) begin
        tx_cnt <= tx_cnt + DIV_W'(1);
      end else begin
        tx_cnt <= '0;
        tx_bit <= tx_bit + BCW'(1);
        case (tx_state)
          TX_START: begin
            tx_bit   <= '0;
            tx_state <= TX_DATA;
          end
          TX_DATA: begin
            tx_sh <= tx_sh >> 1;
            if (tx_bit == BCW'(DATA_BITS - 1)) begin
              tx_bit   <= '0;
              tx_state <= (PAR_MODE != PAR_NONE) ? TX_PAR : TX_STOP;
            end
          end
          TX_PAR: begin
            tx_bit   <= '0;
            tx_state <= TX_STOP;
          end
          TX_STOP: begin
            if (tx_bit == BCW'(STOP_BITS - 1)) begin
              tx_bit   <= '0;
              tx_state <= TX_GUARD;
            end
          end
          default: begin
            if (tx_bit == BCW'(GUARD_BITS - 1)) tx_state <= TX_IDLE;
          end
        endcase
      end
    end
  end

  // ---------------- RX ----------------
  rx_state_e            rx_state;
  logic [DIV_W-1:0]     rx_div, rx_cnt;
  logic [BCW-1:0]       rx_bit;
  logic [DATA_BITS-1:0] rx_sh;
  logic                 sync1, sync2, armed, rx_perr, rx_ferr, rx_tick;

  assign rx_tick = (rx_cnt == rx_div - DIV_W'(1));

  // armed means the line has been seen high, so a later low is a genuine falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      rx_state <= RX_IDLE;
      rx_div   <= DIV_W'(MIN_BAUD_DIV);
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_perr  <= 1'b0;
      rx_ferr  <= 1'b0;
      armed    <= 1'b0;
    end else begin
      sync1 <= serial_i;
      sync2 <= sync1;
      if (serial_oe) begin
        rx_state <= RX_IDLE;
        armed    <= 1'b0;
      end else begin
        case (rx_state)
          RX_IDLE: begin
            if (armed && !sync2) begin
              rx_state <= RX_START_CHK;
              rx_div   <= div_eff;
              rx_cnt   <= '0;
              rx_perr  <= 1'b0;
              armed    <= 1'b0;
            end else begin
              armed <= sync2;
            end
          end
          RX_START_CHK: begin
            if (rx_cnt == (rx_div >> 1)) begin
              rx_cnt   <= '0;
              rx_bit   <= '0;
              rx_state <= sync2 ? RX_IDLE : RX_DATA;
            end else begin
              rx_cnt <= rx_cnt + DIV_W'(1);
            end
          end
          RX_PUSH: rx_state <= RX_IDLE;
          default: begin
            if (!rx_tick) begin
              rx_cnt <= rx_cnt + DIV_W'(1);
            end else begin
              rx_cnt <= '0;
              if (rx_state == RX_DATA) begin
                rx_sh  <= {sync2, rx_sh[DATA_BITS-1:1]};
                rx_bit <= rx_bit + BCW'(1);
                if (rx_bit == BCW'(DATA_BITS - 1))
                  rx_state <= (PAR_MODE != PAR_NONE) ? RX_PAR : RX_STOP;
              end else if (rx_state == RX_PAR) begin
                rx_perr  <= sync2 ^ parity_calc(9'(rx_sh), PAR_MODE);
                rx_state <= RX_STOP;
              end else begin
                rx_ferr  <= ~sync2;
                rx_state <= RX_PUSH;
              end
            end
          end
        endcase
      end
    end
  end

  // ---------------- FIFO ----------------
  logic                 push, full, empty;
  logic [DATA_BITS+1:0] rdata;

  assign push = (rx_state == RX_PUSH);

  ttl_uart_fifo #(
    .WIDTH(DATA_BITS + 2),
    .DEPTH(RX_FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (rx_ready),
    .wdata({rx_perr, rx_ferr, rx_sh}),
    .rdata(rdata),
    .full (full),
    .empty(empty)
  );

  assign rx_valid = ~empty;
  assign rx_data  = empty ? '0 : rdata[DATA_BITS-1:0];
  assign rx_err   = empty ? '0 : rdata[DATA_BITS+:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          rx_overrun <= 1'b0;
    else if (push && full && !rx_ready)  rx_overrun <= 1'b1;
    else if (clr_overrun)                rx_overrun <= 1'b0;
  end

endmodule
